load_store_unit: RTL

//  Sits between the core's memory-stage request port and the word-addressed data

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response port of the load/store unit.
// master = memory-stage requester, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, req_address, req_wdata,
    input  req_ready, resp_valid, resp_error,
    input  resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_address, req_wdata,
    output req_ready, resp_valid, resp_error,
    output resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-addressed memory
// that reads on the rising edge and writes on the falling edge.
module load_store_unit #(
  parameter int MEMORY_SIZE_WORDS = 256
) (
  input  logic                clock,
  input  logic                reset_n,
  load_store_unit_if.slave    bus,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_input_data,
  output logic                mem_should_write,
  input  logic [31:0]         mem_output_data
);

  localparam logic [31:0] LIMIT =
    32'(4 * MEMORY_SIZE_WORDS);

  typedef enum logic [1:0] {
    IDLE, READ, CAPTURE, WRITE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_write;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_err;
  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merge;
  logic [31:0] w_store;

  assign w_accept = bus.req_valid & (r_state == IDLE);

  assign w_err =
    (bus.req_size == 2'd3) |
    ((bus.req_size == 2'd1) & bus.req_address[0]) |
    ((bus.req_size == 2'd2) &
     (bus.req_address[1:0] != 2'b00)) |
    (bus.req_address >= LIMIT);

  assign w_shift = {r_addr[1:0], 3'b000};
  assign w_lane  = mem_output_data >> w_shift;

  always_comb begin
    w_load = w_lane;
    unique case (r_size)
      2'd0: w_load = r_uns ?
        {24'd0, w_lane[7:0]} :
        {{24{w_lane[7]}}, w_lane[7:0]};
      2'd1: w_load = r_uns ?
        {16'd0, w_lane[15:0]} :
        {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  // Sub-word stores splice the new lane into the word read in READ.
  always_comb begin
    w_mask = (r_size == 2'd0) ? 32'h0000_00FF
                              : 32'h0000_FFFF;
    w_merge = (mem_output_data & ~(w_mask << w_shift)) |
              ((r_wdata & w_mask) << w_shift);
    w_store = (r_size == 2'd2) ? r_wdata : w_merge;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !w_err)
          w_next = (bus.req_write &&
                    bus.req_size == 2'd2) ? WRITE : READ;
      end
      READ:    w_next = r_write ? WRITE : CAPTURE;
      CAPTURE: w_next = IDLE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = (r_state == IDLE);
    mem_should_write = (r_state == WRITE) & reset_n;
    mem_input_data   = (r_state == WRITE) ? w_store : '0;
  end

  assign mem_address     = {r_addr[31:2], 2'b00};
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_error  = r_resp_error;
  assign bus.resp_rdata  = r_resp_rdata;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.req_address;
        r_size  <= bus.req_size;
        r_uns   <= bus.req_unsigned;
        r_write <= bus.req_write;
        r_wdata <= bus.req_wdata;
      end
      r_resp_valid <= (w_accept & w_err) |
                      (r_state == CAPTURE) |
                      (r_state == WRITE);
      r_resp_error <= w_accept & w_err;
      r_resp_rdata <= (r_state == CAPTURE) ? w_load : '0;
    end
  end

endmodule
